// File: rtl/handshake_pkg.sv
// Shared constants and helpers for the handshake_pair link.
// Contents: LFSR width and tap mask, default data width, LFSR step function.
package handshake_pkg;

  localparam int unsigned LFSR_W            = 8;
  // Taps at bits 7,5,4,3 (x^8 + x^6 + x^5 + x^4 + 1, maximal length).
  localparam logic [LFSR_W-1:0] LFSR_TAPS   = 8'hB8;
  localparam int unsigned DEFAULT_DATA_BITS = 8;

  typedef logic [LFSR_W-1:0] lfsr_t;

  // One Fibonacci step: shift left, feedback enters at bit 0.
  function automatic lfsr_t lfsr_next(input lfsr_t s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/handshake_pair_if.sv
// Valid/ready channel bundle.
// Signals: valid, data[DATA_BITS], ready.
// Modports: master (drives valid/data), slave (drives ready),
//           link (a block that owns both ends and drives all three).
interface handshake_pair_if #(
  parameter int unsigned DATA_BITS = handshake_pkg::DEFAULT_DATA_BITS
);

  logic                 valid;
  logic [DATA_BITS-1:0] data;
  logic                 ready;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
  modport link   (output valid, output data, output ready);

endinterface

// File: rtl/handshake_fifo.sv
// Synchronous FIFO with full/empty flags; holds the master's queued beats.
// Ports: clk, rst (async, active-high), i_push/i_data (write), i_pop (read),
//        o_head (current head), o_full, o_empty.
// Pushes while full and pops while empty are ignored.
module handshake_fifo #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_pop,
  output logic [DATA_BITS-1:0] o_head,
  output logic                 o_full,
  output logic                 o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic                 w_push;
  logic                 w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage; contents are never observed while empty, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/handshake_pair.sv
// Valid/ready point-to-point link: a queued master feeding a slave whose ready
// is either constant or driven by an LFSR backpressure pattern.
// Ports: clk, rst (async, active-high)
//        put_if (slave)  : put valid/data in, put ready (= !full) out
//        bus_if (link)   : bus valid, data (0 when idle), ready
//        rx_valid        : one-cycle pulse per accepted beat
//        rx_data         : last accepted beat
//        beat_count[16]  : accepted-beat counter, wraps
//        proto_err       : sticky protocol violation flag, present only when
//                          HANDSHAKE_PROTO_CHECK_EN is defined
module handshake_pair import handshake_pkg::*; #(
  parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS,
  parameter bit          ALWAYS_READY = 1'b1,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter lfsr_t       READY_SEED   = 8'h01,
  parameter int unsigned MAX_STALL    = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  handshake_pair_if.slave      put_if,
  handshake_pair_if.link       bus_if,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic [15:0]          beat_count
`ifdef HANDSHAKE_PROTO_CHECK_EN
  ,
  output logic                 proto_err
`endif
);

  typedef logic [DATA_BITS-1:0] beat_t;

  localparam int unsigned STALL_W = $clog2(MAX_STALL + 1);

  logic               w_full;
  logic               w_empty;
  beat_t              w_head;
  beat_t              w_data;
  logic               w_valid;
  logic               w_ready;
  logic               w_xfer;
  lfsr_t              r_lfsr;
  logic [STALL_W-1:0] r_stall;
  logic               r_rx_valid;
  beat_t              r_rx_data;
  logic [15:0]        r_beat_count;

  // Master queue; popped on every bus transfer.
  handshake_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (put_if.valid),
    .i_data  (put_if.data),
    .i_pop   (w_xfer),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign put_if.ready = !w_full;
  assign w_valid      = !w_empty;
  assign w_data       = w_empty ? '0 : w_head;
  // Ready depends only on registers, never on valid: no combinational loop.
  assign w_ready      = ALWAYS_READY ? 1'b1
                      : (r_lfsr[0] || (r_stall == STALL_W'(MAX_STALL)));
  assign w_xfer       = w_valid && w_ready;

  assign bus_if.valid = w_valid;
  assign bus_if.data  = w_data;
  assign bus_if.ready = w_ready;

  // Backpressure pattern and stall counter that forces ready after MAX_STALL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr  <= READY_SEED;
      r_stall <= '0;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
      if (w_xfer || !w_valid) r_stall <= '0;
      else                    r_stall <= r_stall + STALL_W'(1);
    end
  end

  // Slave capture register and accepted-beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_valid   <= 1'b0;
      r_rx_data    <= '0;
      r_beat_count <= '0;
    end else begin
      r_rx_valid <= w_xfer;
      if (w_xfer) begin
        r_rx_data    <= w_data;
        r_beat_count <= r_beat_count + 16'd1;
      end
    end
  end

  assign rx_valid   = r_rx_valid;
  assign rx_data    = r_rx_data;
  assign beat_count = r_beat_count;

`ifdef HANDSHAKE_PROTO_CHECK_EN
  logic  r_prev_stall;
  beat_t r_prev_data;
  logic  r_proto_err;

  // A stalled beat must keep valid high and data stable until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_stall <= 1'b0;
      r_prev_data  <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_prev_stall <= w_valid && !w_ready;
      r_prev_data  <= w_data;
      if (r_prev_stall && (!w_valid || (w_data != r_prev_data)))
        r_proto_err <= 1'b1;
    end
  end

  assign proto_err = r_proto_err;
`else
  // Checker not built: no proto_err port.
`endif

endmodule

// File: tb/tb_handshake_pair.sv
// Directed bench for handshake_pair: three instances share clk/rst.
//   u_a: ALWAYS_READY=1
//   u_b: LFSR ready, seed 8'h01, MAX_STALL=7
//   u_c: LFSR ready, seed 8'h1A (seven low ready cycles from reset), MAX_STALL=5
module tb_handshake_pair;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  handshake_pair_if #(.DATA_BITS(8)) a_put ();
  handshake_pair_if #(.DATA_BITS(8)) a_bus ();
  handshake_pair_if #(.DATA_BITS(8)) b_put ();
  handshake_pair_if #(.DATA_BITS(8)) b_bus ();
  handshake_pair_if #(.DATA_BITS(8)) c_put ();
  handshake_pair_if #(.DATA_BITS(8)) c_bus ();

  logic        a_rx_valid, b_rx_valid, c_rx_valid;
  logic [7:0]  a_rx_data,  b_rx_data,  c_rx_data;
  logic [15:0] a_beat_count, b_beat_count, c_beat_count;
`ifdef HANDSHAKE_PROTO_CHECK_EN
  logic        a_proto_err, b_proto_err, c_proto_err;
`endif

  handshake_pair #(.DATA_BITS(8), .ALWAYS_READY(1'b1), .FIFO_DEPTH(4),
                   .READY_SEED(8'h01), .MAX_STALL(7)) u_a (
    .clk(clk), .rst(rst), .put_if(a_put), .bus_if(a_bus),
    .rx_valid(a_rx_valid), .rx_data(a_rx_data), .beat_count(a_beat_count)
`ifdef HANDSHAKE_PROTO_CHECK_EN
    , .proto_err(a_proto_err)
`endif
  );

  handshake_pair #(.DATA_BITS(8), .ALWAYS_READY(1'b0), .FIFO_DEPTH(4),
                   .READY_SEED(8'h01), .MAX_STALL(7)) u_b (
    .clk(clk), .rst(rst), .put_if(b_put), .bus_if(b_bus),
    .rx_valid(b_rx_valid), .rx_data(b_rx_data), .beat_count(b_beat_count)
`ifdef HANDSHAKE_PROTO_CHECK_EN
    , .proto_err(b_proto_err)
`endif
  );

  handshake_pair #(.DATA_BITS(8), .ALWAYS_READY(1'b0), .FIFO_DEPTH(4),
                   .READY_SEED(8'h1A), .MAX_STALL(5)) u_c (
    .clk(clk), .rst(rst), .put_if(c_put), .bus_if(c_bus),
    .rx_valid(c_rx_valid), .rx_data(c_rx_data), .beat_count(c_beat_count)
`ifdef HANDSHAKE_PROTO_CHECK_EN
    , .proto_err(c_proto_err)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one put request for a single clock on the selected instance.
  task automatic push(input int dut, input logic [7:0] d);
    case (dut)
      0:       begin a_put.valid = 1'b1; a_put.data = d; end
      1:       begin b_put.valid = 1'b1; b_put.data = d; end
      default: begin c_put.valid = 1'b1; c_put.data = d; end
    endcase
    tick();
    a_put.valid = 1'b0;
    b_put.valid = 1'b0;
    c_put.valid = 1'b0;
  endtask

  task automatic reset_all();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  logic [7:0] c_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    int got_n;
    int rx_seen;
    a_put.valid = 1'b0; a_put.data = '0;
    b_put.valid = 1'b0; b_put.data = '0;
    c_put.valid = 1'b0; c_put.data = '0;

    // Always-ready: back-to-back transfers.
    reset_all();
    check_eq("a_rst_valid", 32'(a_bus.valid), 0);
    check_eq("a_rst_data",  32'(a_bus.data), 0);
    check_eq("a_rst_ready", 32'(a_bus.ready), 1);
    check_eq("a_rst_putrdy", 32'(a_put.ready), 1);
    check_eq("a_rst_rxv",   32'(a_rx_valid), 0);
    check_eq("a_rst_rxd",   32'(a_rx_data), 0);
    check_eq("a_rst_cnt",   32'(a_beat_count), 0);
    push(0, 8'hA5);
    check_eq("a_e1_valid", 32'(a_bus.valid), 1);
    check_eq("a_e1_data",  32'(a_bus.data), 'hA5);
    check_eq("a_e1_rxv",   32'(a_rx_valid), 0);
    push(0, 8'hC4);
    check_eq("a_e2_rxv",  32'(a_rx_valid), 1);
    check_eq("a_e2_rxd",  32'(a_rx_data), 'hA5);
    check_eq("a_e2_data", 32'(a_bus.data), 'hC4);
    check_eq("a_e2_cnt",  32'(a_beat_count), 1);
    tick();
    check_eq("a_e3_rxv",   32'(a_rx_valid), 1);
    check_eq("a_e3_rxd",   32'(a_rx_data), 'hC4);
    check_eq("a_e3_cnt",   32'(a_beat_count), 2);
    check_eq("a_e3_valid", 32'(a_bus.valid), 0);
    check_eq("a_e3_data",  32'(a_bus.data), 0);
    tick();
    check_eq("a_e4_rxv", 32'(a_rx_valid), 0);

    // LFSR ready (seed 01): ready pattern 1,0,0,0,1,1,1,0,0,0 from reset.
    reset_all();
    check_eq("b_rst_ready", 32'(b_bus.ready), 1);
    check_eq("b_rst_valid", 32'(b_bus.valid), 0);
    push(1, 8'hA5);
    check_eq("b_e1_valid", 32'(b_bus.valid), 1);
    check_eq("b_e1_data",  32'(b_bus.data), 'hA5);
    check_eq("b_e1_ready", 32'(b_bus.ready), 0);
    push(1, 8'hC4);
    check_eq("b_e2_data",  32'(b_bus.data), 'hA5);
    check_eq("b_e2_ready", 32'(b_bus.ready), 0);
    tick();
    check_eq("b_e3_valid", 32'(b_bus.valid), 1);
    check_eq("b_e3_data",  32'(b_bus.data), 'hA5);
    check_eq("b_e3_rxv",   32'(b_rx_valid), 0);
    tick();
    check_eq("b_e4_ready", 32'(b_bus.ready), 1);
    check_eq("b_e4_data",  32'(b_bus.data), 'hA5);
    check_eq("b_e4_rxv",   32'(b_rx_valid), 0);
    tick();
    check_eq("b_e5_rxv",  32'(b_rx_valid), 1);
    check_eq("b_e5_rxd",  32'(b_rx_data), 'hA5);
    check_eq("b_e5_data", 32'(b_bus.data), 'hC4);
    tick();
    check_eq("b_e6_rxv",   32'(b_rx_valid), 1);
    check_eq("b_e6_rxd",   32'(b_rx_data), 'hC4);
    check_eq("b_e6_cnt",   32'(b_beat_count), 2);
    check_eq("b_e6_valid", 32'(b_bus.valid), 0);

    // Queue three beats while ready is low, then reset mid-stall.
    push(1, 8'hD1);
    push(1, 8'hD2);
    push(1, 8'hD3);
    check_eq("b_q3_valid", 32'(b_bus.valid), 1);
    check_eq("b_q3_data",  32'(b_bus.data), 'hD1);
    check_eq("b_q3_ready", 32'(b_bus.ready), 0);
    check_eq("b_q3_cnt",   32'(b_beat_count), 2);
    rst = 1'b1;
    #1;
    check_eq("b_arst_valid",  32'(b_bus.valid), 0);
    check_eq("b_arst_data",   32'(b_bus.data), 0);
    check_eq("b_arst_cnt",    32'(b_beat_count), 0);
    check_eq("b_arst_putrdy", 32'(b_put.ready), 1);
    rx_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 1) rst = 1'b0;
      if (b_rx_valid) rx_seen++;
    end
    check_eq("b_post_rst_rx",    32'(rx_seen), 0);
    check_eq("b_post_rst_cnt",   32'(b_beat_count), 0);
    check_eq("b_post_rst_valid", 32'(b_bus.valid), 0);

    // Fill while ready is low, drop a push while full, forced ready, drain.
    reset_all();
    check_eq("c_rst_ready",  32'(c_bus.ready), 0);
    check_eq("c_rst_putrdy", 32'(c_put.ready), 1);
    push(2, 8'h11);
    check_eq("c_p1_valid", 32'(c_bus.valid), 1);
    check_eq("c_p1_data",  32'(c_bus.data), 'h11);
    push(2, 8'h22);
    push(2, 8'h33);
    check_eq("c_p3_putrdy", 32'(c_put.ready), 1);
    check_eq("c_p3_ready",  32'(c_bus.ready), 0);
    push(2, 8'h44);
    check_eq("c_full_putrdy", 32'(c_put.ready), 0);
    check_eq("c_full_data",   32'(c_bus.data), 'h11);
    push(2, 8'h55);
    check_eq("c_drop_putrdy", 32'(c_put.ready), 0);
    check_eq("c_stall4_ready", 32'(c_bus.ready), 0);
    check_eq("c_stall4_cnt",   32'(c_beat_count), 0);
    tick();
    check_eq("c_forced_ready", 32'(c_bus.ready), 1);
    check_eq("c_forced_data",  32'(c_bus.data), 'h11);
    got_n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (c_rx_valid) begin
        if (got_n < 4) check_eq("c_drain_order", 32'(c_rx_data), 32'(c_exp[got_n]));
        got_n++;
      end
    end
    check_eq("c_drain_beats",  32'(got_n), 4);
    check_eq("c_drain_cnt",    32'(c_beat_count), 4);
    check_eq("c_drain_valid",  32'(c_bus.valid), 0);
    check_eq("c_drain_putrdy", 32'(c_put.ready), 1);

`ifdef HANDSHAKE_PROTO_CHECK_EN
    check_eq("a_proto_err", 32'(a_proto_err), 0);
    check_eq("b_proto_err", 32'(b_proto_err), 0);
    check_eq("c_proto_err", 32'(c_proto_err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
